// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_pkg
// Description : Address map of the 8-bit IO bus and the console master's
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

  // Peripheral register addresses
  localparam logic [7:0] IO_OUT0  = 8'h00;  // LED result port, bits [4:0]
  localparam logic [7:0] IO_READY = 8'h04;  // master-driven ready flag
  localparam logic [7:0] IO_OUT1  = 8'h08;  // 7-segment display port
  localparam logic [7:0] IO_IN    = 8'h0c;  // 5-bit switch value
  localparam logic [7:0] IO_VALID = 8'h10;  // peripheral-driven valid flag

  // Console master states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_ISSUE  = 4'd1,
    ST_WR_ACK    = 4'd2,
    ST_RD_SETRDY = 4'd3,
    ST_RD_WAIT1  = 4'd4,
    ST_RD_GET    = 4'd5,
    ST_RD_CLRRDY = 4'd6,
    ST_RD_WAIT0  = 4'd7,
    ST_RD_ACK    = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/io_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : io_poll_timer
// Description : Saturating poll counter. 'expired' flags the enabled cycle
//               in which the count reaches all-ones (or is already there).
// Revision    : 1.0 - initial release
// ============================================================================
module io_poll_timer #(
  parameter int TMO_W = 16  // must be at least 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] C_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] C_LAST = ~C_ONE;  // all-ones minus one

  logic [TMO_W-1:0] count_q;
  logic [TMO_W-1:0] count_d;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + C_ONE;
    end
  end

  assign expired = en && (count_q >= C_LAST);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_console_master.sv
`default_nettype none
// ============================================================================
// Module      : io_console_master
// Description : IO bus initiator running the console protocol in hardware:
//               four-phase ready/valid reads of the switch port and
//               single-cycle stores to the LED / display ports.
// Revision    : 1.0 - initial release
// ============================================================================
module io_console_master
  import io_bus_pkg::*;
#(
  parameter int TMO_W  = 16,   // must be at least 1
  parameter bit TMO_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [4:0]  rd_data,
  output logic        rd_err,
  input  logic        wr_req,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic [7:0]  io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  input  logic [31:0] io_din
);

  state_e      state_q, state_d;
  logic [7:0]  io_addr_q, io_addr_d;
  logic [31:0] io_dout_q, io_dout_d;
  logic        io_we_q, io_we_d;
  logic        rd_ack_q, rd_ack_d;
  logic        wr_ack_q, wr_ack_d;
  logic        rd_err_q, rd_err_d;
  logic [4:0]  rd_data_q, rd_data_d;
  logic        err_q, err_d;

  logic        tmo_clr;
  logic        tmo_en;
  logic        tmo_expired;
  logic        unused_din;

  // Only the valid flag and the 5-bit switch value matter on the read bus.
  assign unused_din = ^io_din[31:5];

  // The counter runs only while waiting for valid and restarts on every entry.
  assign tmo_clr = (state_q != ST_RD_WAIT1);
  assign tmo_en  = (state_q == ST_RD_WAIT1) && !io_din[0];

  generate
    if (TMO_EN) begin : g_tmo
      io_poll_timer #(
        .TMO_W (TMO_W)
      ) u_poll_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
      );
    end else begin : g_no_tmo
      assign tmo_expired = 1'b0;
    end
  endgenerate

  // Next-state logic; write requests win over reads when both are pending.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (wr_req) begin
          state_d = ST_WR_ISSUE;
        end else if (rd_req) begin
          state_d = ST_RD_SETRDY;
        end
      end
      ST_WR_ISSUE:  state_d = ST_WR_ACK;
      ST_WR_ACK:    state_d = ST_IDLE;
      ST_RD_SETRDY: state_d = ST_RD_WAIT1;
      ST_RD_WAIT1: begin
        if (io_din[0]) begin
          state_d = ST_RD_GET;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_RD_CLRRDY;
        end
      end
      ST_RD_GET: begin
        rd_data_d = io_din[4:0];
        state_d   = ST_RD_CLRRDY;
      end
      // An aborted read never saw valid rise, so there is no fall to wait for.
      ST_RD_CLRRDY: state_d = err_q ? ST_RD_ACK : ST_RD_WAIT0;
      ST_RD_WAIT0: begin
        if (!io_din[0]) begin
          state_d = ST_RD_ACK;
        end
      end
      ST_RD_ACK: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    io_addr_d = IO_VALID;
    io_dout_d = io_dout_q;
    io_we_d   = 1'b0;
    case (state_d)
      ST_WR_ISSUE: begin
        io_we_d   = 1'b1;
        io_addr_d = wr_sel ? IO_OUT1 : IO_OUT0;
        io_dout_d = wr_data;
      end
      ST_RD_SETRDY: begin
        io_we_d   = 1'b1;
        io_addr_d = IO_READY;
        io_dout_d = 32'd1;
      end
      ST_RD_GET: begin
        io_addr_d = IO_IN;
      end
      ST_RD_CLRRDY: begin
        io_we_d   = 1'b1;
        io_addr_d = IO_READY;
        io_dout_d = 32'd0;
      end
      default: begin
      end
    endcase
    wr_ack_d = (state_d == ST_WR_ACK);
    rd_ack_d = (state_d == ST_RD_ACK);
    rd_err_d = (state_d == ST_RD_ACK) && err_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      io_addr_q <= IO_VALID;
      io_dout_q <= 32'd0;
      io_we_q   <= 1'b0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= 5'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      io_addr_q <= io_addr_d;
      io_dout_q <= io_dout_d;
      io_we_q   <= io_we_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign io_addr = io_addr_q;
  assign io_dout = io_dout_q;
  assign io_we   = io_we_q;
  assign rd_ack  = rd_ack_q;
  assign wr_ack  = wr_ack_q;
  assign rd_err  = rd_err_q;
  assign rd_data = rd_data_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_io_console_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_io_console_master
// Description : Scoreboard bench for io_console_master with a small switch /
//               handshake peripheral model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_console_master;
  import io_bus_pkg::*;

  localparam int TMO_W  = 4;
  localparam int K_WR   = 0;
  localparam int K_WACK = 1;
  localparam int K_RACK = 2;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [4:0]  rd_data;
  logic        rd_err;
  logic        wr_req = 1'b0;
  logic        wr_sel = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ack;
  logic        busy;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Peripheral model controls
  logic [4:0] sw_val = 5'd0;
  int         up_delay = -1;
  int         dn_delay = 0;
  int         up_left;
  int         dn_left;
  logic       valid_r;

  always #5 clk = ~clk;

  io_console_master #(
    .TMO_W  (TMO_W),
    .TMO_EN (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .wr_req  (wr_req),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .busy    (busy),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we),
    .io_din  (io_din)
  );

  // Read mux with junk in the bits the master must ignore.
  always_comb begin
    case (io_addr)
      IO_VALID: io_din = {31'h2BAD_F00D, valid_r};
      IO_IN:    io_din = {27'h5A5_A5A5, sw_val};
      default:  io_din = 32'hFFFF_FFFF;
    endcase
  end

  // Valid rises up_delay edges after ready=1 is written, falls dn_delay edges
  // after ready=0 is written; a negative delay means never.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      up_left <= 0;
      dn_left <= 0;
    end else begin
      if (up_left > 0) begin
        up_left <= up_left - 1;
        if (up_left == 1) valid_r <= 1'b1;
      end
      if (dn_left > 0) begin
        dn_left <= dn_left - 1;
        if (dn_left == 1) valid_r <= 1'b0;
      end
      if (io_we && io_addr == IO_READY) begin
        if (io_dout[0]) begin
          if (up_delay == 0) valid_r <= 1'b1;
          else if (up_delay > 0) up_left <= up_delay;
        end else begin
          if (dn_delay == 0) valid_r <= 1'b0;
          else if (dn_delay > 0) dn_left <= dn_delay;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic take(input int kind, input logic [7:0] a, input logic [31:0] d, input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event addr=%0h data=%0h, expected none", nm, a, d);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, 32'(kind), 32'(e.kind));
      chk({nm, "_addr"}, 32'(a), 32'(e.addr));
      chk({nm, "_data"}, d, e.data);
    end
  endtask

  // Scoreboard monitor: every bus write and every ack pops one expectation.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (io_we)  take(K_WR, io_addr, io_dout, "bus_write");
        if (wr_ack) take(K_WACK, 8'h00, 32'h0, "wr_ack");
        if (rd_ack) take(K_RACK, {7'b0, rd_err}, {27'b0, rd_data}, "rd_ack");
      end
    end
  endtask

  task automatic do_write(input logic sel, input logic [31:0] data);
    int n;
    int nb;
    push(K_WR, sel ? IO_OUT1 : IO_OUT0, data);
    push(K_WACK, 8'h00, 32'h0);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_sel = sel; wr_data = data;
    n = 0; nb = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end while (!wr_ack && n < 50);
    wr_req = 1'b0;
    chk("wr_latency", 32'(n), 32'd2);
    chk("wr_busy_cycles", 32'(nb), 32'd2);
    @(posedge clk); #1;
    chk("wr_idle_after", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic [4:0] sw, input int up, input int dn,
                         input logic [4:0] exp_data, input logic exp_err, input int exp_lat);
    int n;
    sw_val = sw; up_delay = up; dn_delay = dn;
    push(K_WR, IO_READY, 32'd1);
    push(K_WR, IO_READY, 32'd0);
    push(K_RACK, {7'b0, exp_err}, {27'b0, exp_data});
    @(posedge clk); #1;
    rd_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rd_ack && n < 200);
    rd_req = 1'b0;
    chk("rd_latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    fork
      monitor();
    join_none

    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_io_addr", 32'(io_addr), 32'h10);
    chk("rst_io_we",   32'(io_we),   32'd0);
    chk("rst_io_dout", io_dout,      32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_acks",    {29'd0, rd_ack, wr_ack, rd_err}, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Writes to both result ports
    do_write(1'b0, 32'h0000_0015);
    do_write(1'b1, 32'hDEAD_BEEF);

    // Full read: valid 10 edges after ready=1, drops 4 edges after ready=0
    do_read(5'h0a, 10, 4, 5'h0a, 1'b0, 20);
    // Timeout: valid never rises, 15 polls, data keeps previous capture
    do_read(5'h11, -1, 0, 5'h0a, 1'b1, 18);
    // Valid already high and dropping at once: minimum latency
    do_read(5'h15, 0, 0, 5'h15, 1'b0, 6);

    // Collision: write served first, then the read
    sw_val = 5'h13; up_delay = 0; dn_delay = 0;
    push(K_WR, IO_OUT0, 32'h0000_0007);
    push(K_WACK, 8'h00, 32'h0);
    push(K_WR, IO_READY, 32'd1);
    push(K_WR, IO_READY, 32'd0);
    push(K_RACK, 8'h00, 32'h13);
    @(posedge clk); #1;
    wr_req = 1'b1; rd_req = 1'b1; wr_sel = 1'b0; wr_data = 32'h0000_0007;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wr_ack && n < 50);
    wr_req = 1'b0;
    chk("col_wr_latency", 32'(n), 32'd2);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rd_ack && n < 200);
    rd_req = 1'b0;
    chk("col_rd_latency", 32'(n), 32'd9);
    @(posedge clk); #1;

    // Reset in the middle of RD_WAIT1
    up_delay = -1;
    push(K_WR, IO_READY, 32'd1);
    @(posedge clk); #1;
    rd_req = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_io_we",   32'(io_we),   32'd0);
    chk("midrst_io_addr", 32'(io_addr), 32'h10);
    chk("midrst_busy",    32'(busy),    32'd0);
    chk("midrst_acks",    {30'd0, rd_ack, wr_ack}, 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    rd_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(5'h1f, 2, 1, 5'h1f, 1'b0, 9);

    repeat (5) @(posedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_console_master.md
Name: io_console_master

Overview:
- CPU-side initiator for the 8-bit-address IO bus: drives io_addr, io_dout and io_we, and samples io_din.
- Runs the console protocol in hardware:
  - Input read: four-phase ready/valid handshake against the 5-bit switch port.
  - Output write: single-cycle stores to the LED/7-seg result ports.
- Sits between the pipeline's MEM-stage IO requests and the debug unit's peripheral ports, so software no longer needs polling loops.

Parameters:
- TMO_W, 16, width of the valid-poll timeout counter; TMO_W=0 is illegal.
- TMO_EN, 1, 1 = abort a read after 2^TMO_W−1 poll cycles in RD_WAIT1; 0 = wait forever.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  request one input value; held high until rd_ack
- rd_ack  out  1  one-cycle pulse; read finished
- rd_data  out  5  captured switch value, valid while rd_ack=1, held until next capture
- rd_err  out  1  with rd_ack: 1 = timeout abort, rd_data unchanged
- wr_req  in  1  request output write; held high until wr_ack
- wr_sel  in  1  0 = LED port (0x00, bits [4:0] used), 1 = display port (0x08)
- wr_data  in  32  write value
- wr_ack  out  1  one-cycle pulse; write issued
- busy  out  1  1 whenever state ≠ IDLE
- io_addr  out  8  bus address (registered)
- io_dout  out  32  bus write data (registered)
- io_we  out  1  bus write strobe, one cycle per write (registered)
- io_din  in  32  bus read data; combinational from io_addr in the peripheral

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; io_addr=8'h10, io_dout=0, io_we=0
  - rd_ack=wr_ack=rd_err=0; rd_data=0; poll counter=0
- All bus outputs are registered. Each state sets them for the following cycle. io_din is sampled at the clk edge while the matching address is on the bus.
- Requests are sampled only in IDLE. Simultaneous rd_req and wr_req: write wins; the read starts after wr_ack.
- Write path:
  - IDLE --wr_req--> WR_ISSUE: io_we=1, io_addr = wr_sel ? 8'h08 : 8'h00, io_dout=wr_data.
  - WR_ISSUE → WR_ACK: wr_ack=1, io_we=0, io_addr=8'h10 → IDLE.
  - Latency: wr_req in IDLE to wr_ack = 2 cycles.
- Read path (four-phase):
  - IDLE --rd_req--> RD_SETRDY: write 1 to 0x04.
  - → RD_WAIT1: io_addr=0x10, poll counter cleared. Stays while io_din[0]==0.
    - TMO_EN=1 and counter reaches all-ones → RD_CLRRDY with err flag set.
  - io_din[0]==1 → RD_GET: io_addr=0x0c. Capture rd_data=io_din[4:0] on the next edge.
  - → RD_CLRRDY: write 0 to 0x04.
  - → RD_WAIT0: io_addr=0x10. Stays while io_din[0]==1, with no timeout.
    - In the err case RD_WAIT0 is skipped.
  - → RD_ACK: rd_ack=1, rd_err=err flag → IDLE. Err flag clears in IDLE.
  - Minimum latency rd_req to rd_ack, with valid already 1 and dropping immediately: 6 cycles.
- Boundaries:
  - valid already 1 when a read starts: proceeds without waiting.
  - Request still high in the cycle after ack: treated as a new transaction.
  - Poll counter saturates; it never wraps.
  - io_din bits other than those listed are ignored.
  - Reset mid-read forces ready low only through the peripheral's own reset. The master always returns to IDLE with io_we=0.

Decomposition:
- Shared package io_bus_pkg:
  - address constants IO_OUT0=8'h00, IO_READY=8'h04, IO_OUT1=8'h08, IO_IN=8'h0c, IO_VALID=8'h10
  - state enum
- One natural sub-module: io_poll_timer (TMO_W-bit saturating counter with clear/enable/expired).
- Everything else stays flat.

Test Plan:
- Write LED: wr_req=1, wr_sel=0, wr_data=32'h0000_0015 → next cycle io_we=1 @0x00, dout 0x15; wr_ack 2 cycles after request; busy high 2 cycles.
- Write display: wr_sel=1, wr_data=32'hDEAD_BEEF → io_we=1 @0x08, dout 32'hDEADBEEF, single-cycle strobe.
- Full read: rd_req; bench raises valid 10 cycles after the ready=1 write, in=5'h0a; drops valid 4 cycles after the ready=0 write → bus sequence 04/1, 10…, 0c, 04/0, 10…; rd_ack with rd_data=5'h0a, rd_err=0.
- Timeout: TMO_W=4, valid never rises → 15 poll cycles, ready=0 write, rd_ack with rd_err=1, rd_data still holds the previous 5'h0a.
- Collision: rd_req and wr_req together in IDLE → write completes first (wr_ack), then the read sequence begins; no overlapping io_we.
- Reset mid-read: rst_n low during RD_WAIT1 → asynchronously io_we=0, io_addr=0x10, busy=0, no ack; a fresh read after release completes normally.
